fir_out_stage: RTL

Downstream stage of the 64-tap 16-bit FIR core. It captures each filtered sample announced by the core's `valid_out` pulse, then applies optional decimation and a saturating power-of-two gain. Results are buffered in a small first-word-fall-through FIFO and drained over a valid/ready stream. It runs on the FIR core's fast clock `clk`.

---
 rtl/fir_out_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fir_out_stage.sv
// fir_out_stage
// Output stage behind the FIR core. It detects each new filtered sample on
// the rising edge of valid_in and keeps one sample in every decim+1. Each kept
// sample gets a saturating power-of-two gain and is written into a
// first-word-fall-through FIFO, which is drained over a valid/ready stream.
//
// Ports
//   clk       in   fast clock shared with the FIR core
//   rstn      in   asynchronous active-low reset
//   valid_in  in   FIR core valid_out; a rising edge marks a new sample
//   data_in   in   FIR core output sample, signed
//   decim     in   keep 1 of every decim+1 samples (0 keeps all)
//   gain      in   left shift 0..3 with saturation
//   clr_ovf   in   clears overflow at the next edge (a same-cycle drop wins)
//   m_valid   out  FIFO head valid
//   m_ready   in   consumer accepts the head word when m_valid is also high
//   m_data    out  FIFO head word
//   level     out  FIFO occupancy
//   overflow  out  sticky flag: a kept sample was dropped on a full FIFO
//   out_count out  number of samples written to the FIFO, wraps at 16 bits
module fir_out_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         valid_in,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic [3:0]                   decim,
  input  logic [1:0]                   gain,
  input  logic                         clr_ovf,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow,
  output logic [15:0]                  out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // The shift is done at DATA_WIDTH+3 bits, so a gain of up to 3 cannot lose
  // bits. The result is in range when the top four bits all equal the sign bit.
  function automatic logic signed [DATA_WIDTH-1:0] sat_gain(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic        [1:0]            sh
  );
    logic signed [DATA_WIDTH+2:0] p;
    logic signed [DATA_WIDTH-1:0] r;
    p = {{3{x[DATA_WIDTH-1]}}, x};
    p = p <<< sh;
    if (p[DATA_WIDTH+2:DATA_WIDTH-1] == {4{p[DATA_WIDTH+2]}})
      r = p[DATA_WIDTH-1:0];
    else if (p[DATA_WIDTH+2])
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return r;
  endfunction

  logic                         vin_q;
  logic [3:0]                   dcnt;
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;
  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  logic                         event_p0;
  logic                         keep_p0;
  logic                         push_p0;
  logic                         pop_p0;
  logic                         full_p0;
  logic                         wr_en_p0;
  logic                         drop_p0;
  logic signed [DATA_WIDTH-1:0] din_p0;
  logic signed [DATA_WIDTH-1:0] gained_p0;

  // ---- stage p0: event detect, decimation select, gain (combinational) ----
  assign din_p0    = data_in;
  assign event_p0  = valid_in & ~vin_q;
  assign keep_p0   = (dcnt == 4'd0);
  assign push_p0   = event_p0 & keep_p0;
  assign pop_p0    = m_valid & m_ready;
  assign full_p0   = (level == LW'(DEPTH));
  // When the FIFO is full, a pop in the same cycle frees the slot being written.
  assign wr_en_p0  = push_p0 & (~full_p0 | pop_p0);
  assign drop_p0   = push_p0 & full_p0 & ~pop_p0;
  assign gained_p0 = sat_gain(din_p0, gain);

  // ---- stage p1: FIFO storage and control state (registered) ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vin_q     <= 1'b0;
      dcnt      <= 4'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      out_count <= 16'd0;
    end else begin
      vin_q <= valid_in;
      // Comparing with >= also resets a counter that is above a newly lowered decim.
      if (event_p0)
        dcnt <= (dcnt >= decim) ? 4'd0 : dcnt + 4'd1;
      if (wr_en_p0) begin
        wr_ptr    <= wr_ptr + PW'(1);
        out_count <= out_count + 16'd1;
      end
      if (pop_p0)
        rd_ptr <= rd_ptr + PW'(1);
      if (wr_en_p0 && !pop_p0)
        level <= level + LW'(1);
      else if (pop_p0 && !wr_en_p0)
        level <= level - LW'(1);
      if (drop_p0)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  // The data array is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en_p0)
      mem[wr_ptr] <= gained_p0;
  end

  // ---- output: fall-through head of the FIFO ----
  assign m_valid = (level != '0);
  assign m_data  = mem[rd_ptr];

endmodule
